// File: rtl/mult_pipe_fu.sv
// mult_pipe_fu: pipelined integer multiply unit (MUL/MULH/MULHSU/MULHU).
// Both operands are extended to 2*XLEN bits when an op is accepted. Each stage
// then folds one CHUNK-wide slice of opb into a running accumulator, so the
// product is complete once the op reaches the last stage.
// The whole pipe moves as one unit under CDB back-pressure. Flush squashes all
// in-flight ops.
// Optional build macro MULT_PIPE_PERF_EN adds the perf_issued and
// perf_stall_cycles counters.
module mult_pipe_fu #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 6,
    parameter int ROB_IDX_W  = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_opa,
    input  logic [XLEN-1:0]      in_opb,
    input  logic [1:0]           in_func,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
`ifdef MULT_PIPE_PERF_EN
    output logic                 busy,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall_cycles
`else
    output logic                 busy
`endif
);

    localparam int W2    = 2 * XLEN;
    localparam int CHUNK = W2 / NUM_STAGES;
    localparam logic [1:0] FUNC_MUL   = 2'b00;
    localparam logic [1:0] FUNC_MULHU = 2'b11;

    logic [NUM_STAGES-1:0] stage_valid;
    logic                  advance;
    logic                  accept;
    logic [W2-1:0]         ext_opa;
    logic [W2-1:0]         ext_opb;

    // Stage registers (payload is not reset; only the valid bits are)
    logic [W2-1:0]        acc_q  [NUM_STAGES];
    logic [W2-1:0]        opa_q  [NUM_STAGES];
    logic [W2-1:0]        opb_q  [NUM_STAGES];
    logic [1:0]           func_q [NUM_STAGES];
    logic [TAG_W-1:0]     tag_q  [NUM_STAGES];
    logic [ROB_IDX_W-1:0] rob_q  [NUM_STAGES];

    // What each stage sees at its input, and its updated accumulator
    logic [W2-1:0]        src_acc  [NUM_STAGES];
    logic [W2-1:0]        src_opa  [NUM_STAGES];
    logic [W2-1:0]        src_opb  [NUM_STAGES];
    logic [1:0]           src_func [NUM_STAGES];
    logic [TAG_W-1:0]     src_tag  [NUM_STAGES];
    logic [ROB_IDX_W-1:0] src_rob  [NUM_STAGES];
    logic [W2-1:0]        acc_d    [NUM_STAGES];

    assign advance  = !stage_valid[NUM_STAGES-1] || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && in_ready && !flush;

    // Operand extension: opa is unsigned only for MULHU, opb is unsigned for MULHSU/MULHU
    always_comb begin
        ext_opa = (in_func == FUNC_MULHU) ? {{XLEN{1'b0}}, in_opa}
                                          : {{XLEN{in_opa[XLEN-1]}}, in_opa};
        ext_opb = in_func[1] ? {{XLEN{1'b0}}, in_opb}
                             : {{XLEN{in_opb[XLEN-1]}}, in_opb};
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_acc[k]  = '0;
            assign src_opa[k]  = ext_opa;
            assign src_opb[k]  = ext_opb;
            assign src_func[k] = in_func;
            assign src_tag[k]  = in_tag;
            assign src_rob[k]  = in_rob_idx;
        end else begin : g_body
            assign src_acc[k]  = acc_q[k-1];
            assign src_opa[k]  = opa_q[k-1];
            assign src_opb[k]  = opb_q[k-1];
            assign src_func[k] = func_q[k-1];
            assign src_tag[k]  = tag_q[k-1];
            assign src_rob[k]  = rob_q[k-1];
        end
        // Chunks are treated as unsigned. Their weighted sum equals ext_opb
        // modulo 2^W2, so the final accumulator is the full signed or unsigned
        // product.
        assign acc_d[k] = src_acc[k]
                        + ((src_opa[k] * W2'(src_opb[k][k*CHUNK +: CHUNK])) << (k*CHUNK));
    end

    // Payload shifts with the pipe and holds while stalled
    always_ff @(posedge clock) begin
        if (advance) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                acc_q[k]  <= acc_d[k];
                opa_q[k]  <= src_opa[k];
                opb_q[k]  <= src_opb[k];
                func_q[k] <= src_func[k];
                tag_q[k]  <= src_tag[k];
                rob_q[k]  <= src_rob[k];
            end
        end
    end

    // Valid bits: reset and flush squash everything and take priority over advance
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            stage_valid <= '0;
        end else if (advance) begin
            stage_valid[0] <= in_valid;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    assign out_valid = stage_valid[NUM_STAGES-1];
    assign busy      = |stage_valid;

    // Output word select, forced to zero when no result is presented
    always_comb begin
        out_result  = '0;
        out_tag     = '0;
        out_rob_idx = '0;
        if (out_valid) begin
            out_result  = (func_q[NUM_STAGES-1] == FUNC_MUL) ? acc_q[NUM_STAGES-1][XLEN-1:0]
                                                             : acc_q[NUM_STAGES-1][W2-1:XLEN];
            out_tag     = tag_q[NUM_STAGES-1];
            out_rob_idx = rob_q[NUM_STAGES-1];
        end
    end

`ifdef MULT_PIPE_PERF_EN
    // Perf counters survive flush; only reset clears them
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_issued       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (accept) perf_issued <= perf_issued + 32'd1;
            if (out_valid && !out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mult_pipe_fu.md
Name: mult_pipe_fu

Overview:
- Parametrised, pipelined integer multiply functional unit for the out-of-order core's execute stage.
- Successor to the single-cycle combinational multiplier: the product is split into NUM_STAGES partial-product steps, with a valid/ready handshake, CDB back-pressure and squash on flush.
- Sits between the issue/execute register (issue side) and the complete/CDB arbiter (result side).
- Carries physical destination tag and ROB index alongside each operation.

Parameters:
- XLEN, 32, operand/result width.
- NUM_STAGES, 4, pipeline depth = latency in cycles. Must divide 2*XLEN; legal values 1, 2, 4, 8.
- TAG_W, 6, physical register tag width.
- ROB_IDX_W, 5, ROB index width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  squash all in-flight operations (mispredict recovery).
- in_valid  in  1  issue side presents an operation.
- in_ready  out  1  unit accepts the operation this cycle.
- in_opa  in  XLEN  rs1 value.
- in_opb  in  XLEN  rs2 value.
- in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- in_tag  in  TAG_W  destination physical register.
- in_rob_idx  in  ROB_IDX_W  ROB entry.
- out_valid  out  1  result available at last stage.
- out_ready  in  1  CDB/complete stage takes result this cycle.
- out_result  out  XLEN  selected product word.
- out_tag  out  TAG_W  destination tag of output op.
- out_rob_idx  out  ROB_IDX_W  ROB index of output op.
- busy  out  1  any stage holds a valid op.

Behaviour:
- Accept: transfer occurs when in_valid && in_ready && !flush.
- Advance: advance = !stage_valid[NUM_STAGES-1] || out_ready. The whole pipe shifts as one unit. in_ready = advance. No bubble collapsing.
- Output: transfer occurs when out_valid && out_ready. out_valid = stage_valid[NUM_STAGES-1].
- Latency: exactly NUM_STAGES cycles from accept to out_valid with no stalls. Throughput is 1 op/cycle.
- Operand extension at accept, to 2*XLEN bits:
  - opa is sign-extended for MUL, MULH, MULHSU; zero-extended for MULHU.
  - opb is sign-extended for MUL, MULH; zero-extended for MULHSU, MULHU.
- Per-stage arithmetic: CHUNK = 2*XLEN/NUM_STAGES. Stage k (0-based) adds (ext_opa * ext_opb[k*CHUNK +: CHUNK]) << (k*CHUNK) into a 2*XLEN-bit accumulator. Arithmetic is modulo 2^(2*XLEN). The accumulator starts at 0.
- Per-stage payload: valid, accumulator, ext_opa, ext_opb, func, tag, rob_idx.
- out_result: accumulator[XLEN-1:0] for MUL; accumulator[2*XLEN-1:XLEN] otherwise.
- Stall: while !advance, all stage registers hold. Output fields stay stable while out_valid && !out_ready.
- Flush: all stage_valid clear on the next edge. An input presented in the flush cycle is dropped; in_ready is don't-care in that cycle. A result presented with out_ready in the flush cycle counts as taken. Flush has priority over accept and advance.
- Reset (reset_n=0 at edge): all stage_valid=0, out_valid=0, busy=0, in_ready=1 after reset, perf counters=0. Payload registers need not reset; out_result/out_tag/out_rob_idx drive 0 when out_valid=0.
- Reset mid-operation: in-flight ops are discarded, same as flush.
- Ordering: results leave strictly in accept order. No op is lost or duplicated under any out_ready pattern.
- busy = OR of stage_valid.

Optional Feature:
- Macro: MULT_PIPE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] and perf_stall_cycles[31:0].
  - perf_issued increments on each accept.
  - perf_stall_cycles increments each cycle with out_valid && !out_ready.
  - Both cleared by reset, not by flush, and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- MUL opa=7, opb=0xFFFFFFFD, out_ready=1 -> out_valid exactly 4 cycles later (NUM_STAGES=4), out_result=0xFFFFFFEB, tag/rob_idx match input.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Back-to-back 6 ops, tags 1..6, out_ready held low 3 cycles mid-stream -> in_ready low while last stage is full; outputs tags 1..6 in order, values correct, outputs stable during stall.
- 3 ops in flight, flush asserted for 1 cycle along with in_valid -> no out_valid afterwards, busy=0 next cycle, the next accepted op completes normally.
- reset_n low for 1 cycle with ops in flight -> out_valid=0, busy=0, in_ready=1 after reset; with MULT_PIPE_PERF_EN, counters read 0.
- Rerun the MUL/MULH/MULHSU/MULHU vectors with NUM_STAGES=1 and 8 -> latency 1/8 cycles, identical results.
